// File: rtl/parallel_adder_4bit_if.sv
// Operand/result bundle for the 4-bit adder: A/B driven in, S/Cout registered out.
// No handshake; the consumer samples S/Cout one cycle after driving A/B.
interface parallel_adder_4bit_if;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] S;
  logic       Cout;

  modport master (output A, output B, input S, input Cout);
  modport slave  (input A, input B, output S, output Cout);
endinterface

// File: rtl/parallel_adder_4bit.sv
// Unsigned 4-bit ripple-carry adder with registered {Cout,S}.
// Latency: one cycle, with one add accepted every cycle.
// Backpressure: none; the result register loads on every clock.
module parallel_adder_4bit (
  input  logic                  clk,
  input  logic                  rst_n,
  parallel_adder_4bit_if.slave  bus
);

  logic [4:0] c;
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] t;
  logic [3:0] s;

  assign c[0] = 1'b0;

  // Each stage: two half-adders (p/g, then s/t) merged by an OR on the carries.
  for (genvar i = 0; i < 4; i++) begin : fa
    assign p[i]   = bus.A[i] ^ bus.B[i];
    assign g[i]   = bus.A[i] & bus.B[i];
    assign s[i]   = p[i] ^ c[i];
    assign t[i]   = p[i] & c[i];
    assign c[i+1] = g[i] | t[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.S    <= 4'b0000;
      bus.Cout <= 1'b0;
    end else begin
      bus.S    <= s;
      bus.Cout <= c[4];
    end
  end

endmodule

// File: tb/tb_parallel_adder_4bit.sv
// Bench for parallel_adder_4bit: directed, exhaustive and random operands
// against an arithmetic model of A+B with one cycle of lag.
module tb_parallel_adder_4bit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  parallel_adder_4bit_if pa_if ();

  parallel_adder_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pa_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got Cout=%0b S=%0d, expected Cout=%0b S=%0d",
                  tag, obs[4], obs[3:0], exp[4], exp[3:0]);
  endtask

  function automatic logic [4:0] model_sum(input int a, input int b);
    int sum;
    sum = a + b;
    return sum[4:0];
  endfunction

  function automatic logic [4:0] result();
    return {pa_if.Cout, pa_if.S};
  endfunction

  logic [4:0] last_exp;

  // Drive at negedge, confirm the previous result still holds, then check after the edge.
  task automatic apply(input string tag, input int a, input int b);
    @(negedge clk);
    pa_if.A = a[3:0];
    pa_if.B = b[3:0];
    #1;
    if (rst_n) check({tag, "_hold"}, result(), last_exp);
    @(posedge clk);
    #1;
    last_exp = model_sum(a, b);
    check(tag, result(), last_exp);
  endtask

  int da [7] = '{5, 15, 0, 15, 8, 15, 3};
  int db [7] = '{5, 12, 0, 15, 8,  1, 4};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_exp = 5'd0;
    rst_n    = 1'b0;
    pa_if.A  = 4'd5;
    pa_if.B  = 4'd5;

    // Reset held while clocking: outputs stay cleared.
    #1;
    check("reset_async", result(), 5'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("reset_hold", result(), 5'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    last_exp = model_sum(5, 5);
    check("reset_release", result(), last_exp);

    for (int k = 0; k < 7; k++) apply($sformatf("directed_%0d+%0d", da[k], db[k]), da[k], db[k]);

    // Back-to-back operands, each result lagging one cycle.
    apply("pipe_3+4", 3, 4);
    apply("pipe_9+9", 9, 9);
    apply("pipe_1+14", 1, 14);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        apply($sformatf("sweep_%0d+%0d", i, j), i, j);

    for (int k = 0; k < 200; k++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      apply($sformatf("rand_%0d+%0d", ra, rb), ra, rb);
    end

    // Reset pulse between edges clears immediately; next edge reloads.
    apply("mid_pre", 15, 15);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_async", result(), 5'd0);
    @(negedge clk);
    check("mid_reset_hold", result(), 5'd0);
    rst_n = 1'b1;
    #1;
    check("mid_release_before_edge", result(), 5'd0);
    @(posedge clk);
    #1;
    last_exp = model_sum(15, 15);
    check("mid_release_edge", result(), last_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
